// File: rtl/trb_mem_arbiter.sv
// trb_mem_arbiter: single-port trace memory with alternating read/write turns.
// Define TRB_MEM_OUTREG_EN to add an output register (read latency 2 instead of 1).
module trb_mem_arbiter #(
  parameter int TRB_WIDTH = 32,
  parameter int TRB_ADDR_WIDTH = 5,
  parameter int REJ_CNT_WIDTH = 8
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  output logic                      RW_TURN_O,
  input  logic                      WRITE_I,
  output logic                      WRITE_ALLOW_O,
  output logic                      READ_ALLOW_O,
  input  logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_I,
  input  logic [TRB_WIDTH-1:0]      DMEM_I,
  input  logic [TRB_ADDR_WIDTH-1:0] READ_PTR_I,
  output logic [TRB_WIDTH-1:0]      DMEM_O,
  output logic                      DMEM_VALID_O,
  output logic [TRB_ADDR_WIDTH-1:0] FILL_O,
  output logic [REJ_CNT_WIDTH-1:0]  REJECT_CNT_O
);
  localparam int DEPTH = 1 << TRB_ADDR_WIDTH;
  logic [TRB_WIDTH-1:0] mem [DEPTH];
  logic [TRB_WIDTH-1:0] rd_data;
  logic rd_valid;
  logic do_wr;
  logic do_rd;
  logic rej;
  logic [TRB_ADDR_WIDTH-1:0] wp_inc;
  assign wp_inc = WRITE_PTR_I + TRB_ADDR_WIDTH'(1);
  assign do_wr  = RW_TURN_O & WRITE_I & WRITE_ALLOW_O & ~RST_I;
  assign rej    = RW_TURN_O & WRITE_I & ~WRITE_ALLOW_O;
  assign do_rd  = ~RW_TURN_O & READ_ALLOW_O;
  // Memory array: written only on permitted write turns, never reset
  always_ff @(posedge CLK_I)
    if (do_wr) mem[WRITE_PTR_I] <= DMEM_I;
  // Turn toggle, registered allow/fill flags, reject counter and read port
  always_ff @(posedge CLK_I)
    if (RST_I) begin
      RW_TURN_O     <= 1'b0;
      WRITE_ALLOW_O <= 1'b0;
      READ_ALLOW_O  <= 1'b0;
      FILL_O        <= '0;
      REJECT_CNT_O  <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
    end else begin
      RW_TURN_O     <= ~RW_TURN_O;
      WRITE_ALLOW_O <= wp_inc != READ_PTR_I;
      READ_ALLOW_O  <= WRITE_PTR_I != READ_PTR_I;
      FILL_O        <= WRITE_PTR_I - READ_PTR_I;
      if (rej && ~&REJECT_CNT_O) REJECT_CNT_O <= REJECT_CNT_O + REJ_CNT_WIDTH'(1);
      rd_valid <= do_rd;
      if (do_rd) rd_data <= mem[READ_PTR_I];
    end
`ifdef TRB_MEM_OUTREG_EN
  // Extra output stage: data and valid delayed together by one cycle
  always_ff @(posedge CLK_I)
    if (RST_I) begin
      DMEM_O       <= '0;
      DMEM_VALID_O <= 1'b0;
    end else begin
      DMEM_VALID_O <= rd_valid;
      if (rd_valid) DMEM_O <= rd_data;
    end
`else
  assign DMEM_O       = rd_data;
  assign DMEM_VALID_O = rd_valid;
`endif
endmodule

// File: doc/trb_mem_arbiter.md
Name: trb_mem_arbiter

Overview:
Single-port trace memory plus turn arbiter on the system-clock side of the trace buffer. Consumes the write intent, read/write pointers and write data produced by the logging stage. Returns the read/write turn strobe, the read/write permissions and the read data. Alternates memory access between write and read turns so a single-port RAM serves both pointers without collision.

Parameters:
TRB_WIDTH, 32, data word width in bits
TRB_ADDR_WIDTH, 5, address width; depth = 2**TRB_ADDR_WIDTH
REJ_CNT_WIDTH, 8, width of saturating rejected-write counter

Ports:
CLK_I  in  1  system clock
RST_I  in  1  synchronous active-high reset
RW_TURN_O  out  1  1 = write turn, 0 = read turn; toggles every cycle
WRITE_I  in  1  write intent from logger
WRITE_ALLOW_O  out  1  memory not full
READ_ALLOW_O  out  1  memory not empty
WRITE_PTR_I  in  TRB_ADDR_WIDTH  write address
DMEM_I  in  TRB_WIDTH  write data
READ_PTR_I  in  TRB_ADDR_WIDTH  read address
DMEM_O  out  TRB_WIDTH  read data
DMEM_VALID_O  out  1  one-cycle pulse, DMEM_O updated
FILL_O  out  TRB_ADDR_WIDTH  occupancy, (WRITE_PTR_I - READ_PTR_I) mod depth
REJECT_CNT_O  out  REJ_CNT_WIDTH  count of refused writes, saturating

Behaviour:
- Design has one clock, CLK_I. Reset RST_I is synchronous and active-high.
- Reset values: RW_TURN_O=0, WRITE_ALLOW_O=0, READ_ALLOW_O=0, DMEM_O=0, DMEM_VALID_O=0, FILL_O=0, REJECT_CNT_O=0.
- Memory contents are not reset.
- Turn: the register flips every cycle after reset release. The first cycle after reset is a read turn (0), the second is a write turn (1).
- Allow flags are registered from the pointers sampled each cycle, giving one cycle of latency.
  - full = ((WRITE_PTR_I+1) mod depth == READ_PTR_I)
  - empty = (WRITE_PTR_I == READ_PTR_I)
  - WRITE_ALLOW_O = !full; READ_ALLOW_O = !empty.
  - The one-cycle lag is safe: the next turn of the same kind is two cycles later.
- Write: in a cycle with RW_TURN_O=1 and WRITE_I=1 and WRITE_ALLOW_O=1, mem[WRITE_PTR_I] <= DMEM_I at the clock edge.
- Rejected write: RW_TURN_O=1, WRITE_I=1 and WRITE_ALLOW_O=0.
  - No memory update.
  - REJECT_CNT_O increments and saturates at all-ones.
  - WRITE_I during a read turn is ignored and not counted.
- Read: in a cycle with RW_TURN_O=0 and READ_ALLOW_O=1, mem[READ_PTR_I] is read.
  - DMEM_O updates at the next edge and DMEM_VALID_O=1 for exactly that one cycle. Read latency is 1.
  - If READ_ALLOW_O=0, no read occurs, DMEM_O holds its value and DMEM_VALID_O=0.
- Collisions are impossible by construction: read and write never share a cycle. A read of an address written earlier returns the written data.
- Pointer wrap: all pointer arithmetic is modulo depth. Depth-1 entries are usable; one slot is kept empty to distinguish full from empty.
- FILL_O is registered, depth-1 maximum.
- Reset mid-operation:
  - Any in-flight read is discarded (DMEM_VALID_O forced 0).
  - Turn restarts at read.
  - The counter clears; memory contents are retained.

Optional Feature:
Macro TRB_MEM_OUTREG_EN.
- Defined: an extra output register is added. Read latency is 2, and DMEM_VALID_O is delayed by the same cycle. Reset clears both pipeline stages.
- Undefined: read latency is 1 as above.

Test Plan:
- Reset then idle with pointers W=0, R=0 → RW_TURN_O toggles 0,1,0,1…; READ_ALLOW_O=0, WRITE_ALLOW_O=1 from cycle 1; no DMEM_VALID_O.
- Write 0xA5A5_0001 at W=3 on a write turn, then set R=3, W=4 → next read turn yields DMEM_O=0xA5A5_0001 one cycle later with DMEM_VALID_O pulse; FILL_O=1.
- W=31, R=0 (full) with WRITE_I held high for 6 cycles → memory unchanged, REJECT_CNT_O=3, WRITE_ALLOW_O=0.
- Force 300 rejected writes with REJ_CNT_WIDTH=8 → REJECT_CNT_O saturates at 255.
- Wrap: W=1, R=30 → FILL_O=3, both allows 1; read at 30 and 31 returns the previously written data.
- Assert RST_I during the read turn with a read pending → DMEM_VALID_O stays 0, RW_TURN_O=0 after reset, FILL_O=0; repeat with TRB_MEM_OUTREG_EN defined to confirm 2-cycle latency.
